hs_npu_mem_ordering: RTL and testbench
======================================

HS_NPU_MEM_ORDERING -- requirements
Module: hs_npu_mem_ordering

Interface
REQ-001 Parameter BURST_WORDS, default 2: 32-bit words per AXI burst, matching the downstream memory interface (BURST_LEN+1).
REQ-002 Parameter CNT_W, default 16: width of the burst-count field.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle pulse that launches a transfer job.
REQ-006 dir_i  in  1  job direction, sampled with start_i: 0 = read, 1 = write.
REQ-007 base_addr_i  in  32  job byte address, sampled with start_i.
REQ-008 num_bursts_i  in  CNT_W  job length in bursts, sampled with start_i.
REQ-009 abort_i  in  1  cancels the current job.
REQ-010 busy_o  out  1  job in progress; done_o  out  1  one-cycle pulse at job completion.
REQ-011 mem_ready_i  in  1  memory interface idle or accepting a request; mem_valid_i  in  1  read burst data valid, one-cycle pulse.
REQ-012 mem_read_req_o  out  1  read request; mem_write_valid_o  out  1  write request; mem_invalidate_o  out  1  cancel in-flight read.
REQ-013 request_address_o  out  32  burst byte address.
REQ-014 mem_rdata_i  in  BURST_WORDS x 32  read burst; mem_wdata_o  out  BURST_WORDS x 32  write burst.
REQ-015 rd_data_o  out  32, rd_valid_o  out  1, rd_ready_i  in  1  read word stream to the compute side.
REQ-016 wr_data_i  in  32, wr_valid_i  in  1, wr_ready_o  out  1  write word stream from the compute side.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_REQ, RD_WAIT, RD_DRAIN, WR_FILL, WR_REQ, WR_WAIT and DONE.
REQ-018 In IDLE, start_i SHALL latch the job inputs and set burst index k=0; start_i SHALL be ignored in every state other than IDLE.
REQ-019 A job with num_bursts_i = 0 SHALL go IDLE -> DONE, issue no memory requests, and pulse done_o one cycle after start_i.
REQ-020 Otherwise, start_i SHALL move the FSM to RD_REQ (dir_i = 0) or WR_FILL (dir_i = 1).
REQ-021 request_address_o SHALL equal base + k*BURST_WORDS*4, computed modulo 2^32 (wrap-around permitted).
REQ-022 In RD_REQ, mem_read_req_o SHALL be held high until the cycle in which mem_ready_i is high; that cycle is acceptance, and the FSM SHALL then go to RD_WAIT.
REQ-023 In RD_WAIT, mem_read_req_o SHALL stay high; on mem_valid_i the block SHALL capture all of mem_rdata_i into the burst buffer and go to RD_DRAIN.
REQ-024 In RD_DRAIN, buffer words SHALL be emitted in order 0..BURST_WORDS-1, one per rd_valid_o && rd_ready_i handshake.
REQ-025 rd_data_o SHALL be held stable while rd_valid_o is high and rd_ready_i is low.
REQ-026 After the last word of a burst, the FSM SHALL increment k, then go to RD_REQ if k < num_bursts, else to DONE.
REQ-027 In WR_FILL, wr_ready_o SHALL be high, and accepted words SHALL be packed into mem_wdata_o[0..BURST_WORDS-1] in arrival order.
REQ-028 After BURST_WORDS words have been accepted in WR_FILL, the FSM SHALL go to WR_REQ and drive wr_ready_o low.
REQ-029 In WR_REQ, mem_write_valid_o SHALL be held high with mem_wdata_o stable until acceptance (mem_ready_i high), then the FSM SHALL go to WR_WAIT.
REQ-030 In WR_WAIT, mem_write_valid_o SHALL be low; the first cycle in which mem_ready_i is high, at least one cycle after acceptance, SHALL complete the burst.
REQ-031 On write-burst completion, the FSM SHALL increment k, then go to WR_FILL if k < num_bursts, else to DONE.
REQ-032 DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-033 busy_o SHALL be high in every state except IDLE.
REQ-034 abort_i SHALL have priority over every other event in any non-IDLE state.
REQ-035 On abort_i the block SHALL go to IDLE next cycle, pulse mem_invalidate_o one cycle if the state was RD_REQ or RD_WAIT, discard buffered data, and not assert done_o.
REQ-036 abort_i SHALL have no effect in IDLE.
REQ-037 mem_read_req_o and mem_write_valid_o SHALL never be high in the same cycle.

Reset
REQ-038 While rst_n is low, all outputs SHALL be 0, the state SHALL be IDLE, k and the buffer SHALL be 0, and no requests SHALL be issued.
REQ-039 Reset asserted mid-job SHALL abandon the job immediately, with no done_o pulse.

Verification
REQ-040 Read of 3 bursts, base 0x1000, BURST_WORDS=2 -> addresses 0x1000, 0x1008, 0x1010; 6 words emitted in order; done_o pulses once.
REQ-041 Write of 2 bursts, base 0x2000, 4 words A,B,C,D -> mem_wdata_o {A,B} at 0x2000, then {C,D} at 0x2008; done_o pulses once.
REQ-042 rd_ready_i held low 5 cycles mid-drain -> rd_data_o stable, no word lost or duplicated.
REQ-043 num_bursts_i = 0 -> done_o one cycle after start_i, no requests issued; base 0xFFFFFFF8 with 2 bursts -> second address 0x00000000.
REQ-044 abort_i during RD_WAIT -> mem_invalidate_o one-cycle pulse, IDLE next cycle, no done_o; start_i while busy -> ignored.
REQ-045 rst_n low during WR_REQ -> all outputs 0 immediately; a fresh job after reset runs correctly.

Source files
------------

// File: rtl/hs_npu_mem_ordering.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hs_npu_mem_ordering : burst read/write sequencer between an NPU word stream
// and a request/ready burst memory port.                          rev 1.0
// ---------------------------------------------------------------------------
module hs_npu_mem_ordering #(
  parameter int BURST_WORDS = 2,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         dir_i,
  input  logic [31:0]                  base_addr_i,
  input  logic [CNT_W-1:0]             num_bursts_i,
  input  logic                         abort_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic                         mem_ready_i,
  input  logic                         mem_valid_i,
  output logic                         mem_read_req_o,
  output logic                         mem_write_valid_o,
  output logic                         mem_invalidate_o,
  output logic [31:0]                  request_address_o,
  input  logic [BURST_WORDS-1:0][31:0] mem_rdata_i,
  output logic [BURST_WORDS-1:0][31:0] mem_wdata_o,
  output logic [31:0]                  rd_data_o,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  input  logic [31:0]                  wr_data_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o
);

  localparam int               IDX_W       = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BURST_WORDS - 1);
  localparam logic [31:0]      BURST_BYTES = 32'(BURST_WORDS * 4);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRAIN = 3'd3,
    WR_FILL  = 3'd4,
    WR_REQ   = 3'd5,
    WR_WAIT  = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t                       state_q, state_d;
  logic [31:0]                  base_q, base_d;
  logic [CNT_W-1:0]             nb_q, nb_d;
  logic [CNT_W-1:0]             k_q, k_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [BURST_WORDS-1:0][31:0] buf_q, buf_d;
  logic                         inv_q, inv_d;
  logic [CNT_W:0]               k_next;
  logic                         last_burst;

  // One extra bit so the k+1 < num_bursts test cannot overflow.
  assign k_next     = {1'b0, k_q} + (CNT_W+1)'(1);
  assign last_burst = !(k_next < {1'b0, nb_q});

  assign request_address_o = base_q + 32'(k_q) * BURST_BYTES;
  assign mem_wdata_o       = buf_q;
  assign rd_data_o         = buf_q[idx_q];
  assign mem_invalidate_o  = inv_q;
  assign busy_o            = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      nb_q    <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      nb_q    <= nb_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    nb_d              = nb_q;
    k_d               = k_q;
    idx_d             = idx_q;
    buf_d             = buf_q;
    inv_d             = 1'b0;
    done_o            = 1'b0;
    mem_read_req_o    = 1'b0;
    mem_write_valid_o = 1'b0;
    rd_valid_o        = 1'b0;
    wr_ready_o        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d = base_addr_i;
          nb_d   = num_bursts_i;
          k_d    = '0;
          idx_d  = '0;
          if (num_bursts_i == '0) state_d = DONE;
          else                    state_d = dir_i ? WR_FILL : RD_REQ;
        end
      end
      RD_REQ: begin
        mem_read_req_o = 1'b1;
        if (mem_ready_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        mem_read_req_o = 1'b1;
        if (mem_valid_i) begin
          buf_d   = mem_rdata_i;
          idx_d   = '0;
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            k_d     = k_next[CNT_W-1:0];
            state_d = last_burst ? DONE : RD_REQ;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WR_FILL: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          buf_d[idx_q] = wr_data_i;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = WR_REQ;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WR_REQ: begin
        mem_write_valid_o = 1'b1;
        if (mem_ready_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        // Entered the cycle after acceptance, so any ready seen here completes the burst.
        if (mem_ready_i) begin
          k_d     = k_next[CNT_W-1:0];
          state_d = last_burst ? DONE : WR_FILL;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      inv_d   = (state_q == RD_REQ) || (state_q == RD_WAIT);
      done_o  = 1'b0;
      buf_d   = '0;
      idx_d   = '0;
      k_d     = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hs_npu_mem_ordering.sv
`default_nettype none
// Randomized bench for hs_npu_mem_ordering against a phase-level protocol model.
module tb_hs_npu_mem_ordering;

  localparam int BW = 2;
  localparam int CW = 16;
  localparam int P_RREQ = 0, P_RWAIT = 1, P_DRAIN = 2, P_FILL = 3, P_WREQ = 4, P_WWAIT = 5, P_DONE = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_i, dir_i, abort_i;
  logic [31:0]         base_addr_i;
  logic [CW-1:0]       num_bursts_i;
  logic                busy_o, done_o;
  logic                mem_ready_i, mem_valid_i;
  logic                mem_read_req_o, mem_write_valid_o, mem_invalidate_o;
  logic [31:0]         request_address_o;
  logic [BW-1:0][31:0] mem_rdata_i, mem_wdata_o;
  logic [31:0]         rd_data_o;
  logic                rd_valid_o, rd_ready_i;
  logic [31:0]         wr_data_i;
  logic                wr_valid_i, wr_ready_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hs_npu_mem_ordering #(.BURST_WORDS(BW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .dir_i(dir_i),
    .base_addr_i(base_addr_i), .num_bursts_i(num_bursts_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
    .mem_read_req_o(mem_read_req_o), .mem_write_valid_o(mem_write_valid_o),
    .mem_invalidate_o(mem_invalidate_o), .request_address_o(request_address_o),
    .mem_rdata_i(mem_rdata_i), .mem_wdata_o(mem_wdata_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .wr_data_i(wr_data_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o)
  );

  task automatic drive_idle();
    start_i = 0; dir_i = 0; base_addr_i = '0; num_bursts_i = '0; abort_i = 0;
    mem_ready_i = 0; mem_valid_i = 0; mem_rdata_i = '0;
    rd_ready_i = 0; wr_data_i = '0; wr_valid_i = 0;
  endtask

  // Runs one job cycle by cycle; the model tracks which protocol phase the job is in.
  task automatic run_job(input bit dir, input logic [31:0] base, input int nb,
                         input int abort_ph, input int reset_ph, input bit long_stall);
    logic [31:0] exp_q[$];
    logic [31:0] wbuf[BW];
    logic [31:0] exp_addr, prev_data, exp_w;
    int k, ph, nph, widx, hold;
    bit prev_stall, stalled;
    k = 0; widx = 0; hold = 0; prev_stall = 0; stalled = 0; prev_data = '0;
    for (int i = 0; i < BW; i++) wbuf[i] = '0;
    @(negedge clk);
    drive_idle();
    start_i = 1; dir_i = dir; base_addr_i = base; num_bursts_i = CW'(nb);
    @(negedge clk);
    ph = (nb == 0) ? P_DONE : (dir ? P_FILL : P_RREQ);
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_addr = base + 32'(k * BW * 4);
      n_chk++; if (busy_o !== 1'b1) $display("FAIL busy ph=%0d: got %b want 1", ph, busy_o); else n_pass++;
      n_chk++; if (mem_read_req_o !== (ph == P_RREQ || ph == P_RWAIT))
        $display("FAIL read_req ph=%0d: got %b", ph, mem_read_req_o); else n_pass++;
      n_chk++; if (mem_write_valid_o !== (ph == P_WREQ))
        $display("FAIL write_valid ph=%0d: got %b", ph, mem_write_valid_o); else n_pass++;
      n_chk++; if (rd_valid_o !== (ph == P_DRAIN)) $display("FAIL rd_valid ph=%0d: got %b", ph, rd_valid_o); else n_pass++;
      n_chk++; if (wr_ready_o !== (ph == P_FILL)) $display("FAIL wr_ready ph=%0d: got %b", ph, wr_ready_o); else n_pass++;
      n_chk++; if (mem_invalidate_o !== 1'b0) $display("FAIL invalidate ph=%0d: got %b want 0", ph, mem_invalidate_o); else n_pass++;

      if (abort_ph == ph) begin
        drive_idle();
        abort_i = 1;
        #1;
        n_chk++; if (done_o !== 1'b0) $display("FAIL abort_done ph=%0d: got %b want 0", ph, done_o); else n_pass++;
        @(negedge clk);
        abort_i = 0;
        #1;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL abort_idle ph=%0d: busy got %b want 0", ph, busy_o); else n_pass++;
        n_chk++; if (mem_invalidate_o !== (ph == P_RREQ || ph == P_RWAIT))
          $display("FAIL abort_inv ph=%0d: got %b", ph, mem_invalidate_o); else n_pass++;
        n_chk++; if (done_o !== 1'b0 || mem_read_req_o !== 1'b0)
          $display("FAIL abort_quiet ph=%0d: done %b req %b want 0 0", ph, done_o, mem_read_req_o); else n_pass++;
        @(negedge clk);
        n_chk++; if (mem_invalidate_o !== 1'b0) $display("FAIL inv_pulse_len: got %b want 0", mem_invalidate_o); else n_pass++;
        return;
      end

      n_chk++; if (done_o !== (ph == P_DONE)) $display("FAIL done ph=%0d: got %b", ph, done_o); else n_pass++;

      if (reset_ph == ph) begin
        drive_idle();
        rst_n = 0;
        #1;
        n_chk++; if ({busy_o, done_o, mem_read_req_o, mem_write_valid_o, mem_invalidate_o, rd_valid_o, wr_ready_o} !== 7'b0)
          $display("FAIL reset_ctrl: got %b want 0000000", {busy_o, done_o, mem_read_req_o, mem_write_valid_o,
                   mem_invalidate_o, rd_valid_o, wr_ready_o}); else n_pass++;
        n_chk++; if (request_address_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", request_address_o); else n_pass++;
        n_chk++; if (mem_wdata_o !== '0 || rd_data_o !== 32'h0)
          $display("FAIL reset_data: wdata %h rd %h want 0", mem_wdata_o, rd_data_o); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        return;
      end

      if (prev_stall) begin
        n_chk++; if (rd_data_o !== prev_data) $display("FAIL rd_stable: got %h want %h", rd_data_o, prev_data); else n_pass++;
      end

      drive_idle();
      mem_ready_i = 1'($urandom % 2);
      rd_ready_i  = 1'($urandom % 2);
      wr_valid_i  = 1'($urandom % 2);
      wr_data_i   = $urandom;
      if ($urandom % 6 == 0) begin
        start_i = 1; dir_i = 1'($urandom % 2); base_addr_i = $urandom;
        num_bursts_i = CW'($urandom_range(1, 3));
      end
      nph = ph;
      case (ph)
        P_RREQ: begin
          n_chk++; if (request_address_o !== exp_addr)
            $display("FAIL rd_addr k=%0d: got %h want %h", k, request_address_o, exp_addr); else n_pass++;
          if (mem_ready_i) nph = P_RWAIT;
        end
        P_RWAIT: begin
          if ($urandom % 3 == 0) begin
            mem_valid_i = 1;
            for (int i = 0; i < BW; i++) begin
              mem_rdata_i[i] = $urandom;
              exp_q.push_back(mem_rdata_i[i]);
            end
            widx = 0;
            nph  = P_DRAIN;
          end
        end
        P_DRAIN: begin
          if (long_stall && !stalled && k == 1 && widx == 1) begin hold = 5; stalled = 1; end
          if (hold > 0) begin rd_ready_i = 0; hold--; end
          if (rd_ready_i) begin
            exp_w = exp_q.pop_front();
            n_chk++; if (rd_data_o !== exp_w)
              $display("FAIL rd_word k=%0d w=%0d: got %h want %h", k, widx, rd_data_o, exp_w); else n_pass++;
            widx++;
            if (widx == BW) begin
              widx = 0; k++;
              nph = (k < nb) ? P_RREQ : P_DONE;
            end
          end
        end
        P_FILL: begin
          if (wr_valid_i) begin
            wbuf[widx] = wr_data_i;
            widx++;
            if (widx == BW) begin widx = 0; nph = P_WREQ; end
          end
        end
        P_WREQ: begin
          n_chk++; if (request_address_o !== exp_addr)
            $display("FAIL wr_addr k=%0d: got %h want %h", k, request_address_o, exp_addr); else n_pass++;
          for (int i = 0; i < BW; i++) begin
            n_chk++; if (mem_wdata_o[i] !== wbuf[i])
              $display("FAIL wdata k=%0d w=%0d: got %h want %h", k, i, mem_wdata_o[i], wbuf[i]); else n_pass++;
          end
          if (mem_ready_i) nph = P_WWAIT;
        end
        P_WWAIT: begin
          if (mem_ready_i) begin
            k++;
            nph = (k < nb) ? P_FILL : P_DONE;
          end
        end
        default: begin
          @(negedge clk);
          drive_idle();
          #1;
          n_chk++; if (busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL after_done: busy %b done %b want 0 0", busy_o, done_o); else n_pass++;
          return;
        end
      endcase
      prev_stall = (ph == P_DRAIN) && !rd_ready_i;
      prev_data  = rd_data_o;
      ph = nph;
      @(negedge clk);
    end
    n_chk++;
    $display("FAIL job_timeout: phase %0d after 400 cycles, want job end", ph);
    drive_idle();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if ({busy_o, done_o, mem_read_req_o, mem_write_valid_o, mem_invalidate_o, rd_valid_o, wr_ready_o} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000", {busy_o, done_o, mem_read_req_o,
               mem_write_valid_o, mem_invalidate_o, rd_valid_o, wr_ready_o}); else n_pass++;
    n_chk++; if (request_address_o !== 32'h0 || rd_data_o !== 32'h0 || mem_wdata_o !== '0)
      $display("FAIL reset_buses: addr %h rd %h wdata %h want 0", request_address_o, rd_data_o, mem_wdata_o); else n_pass++;
    rst_n = 1;
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_idle_abort();
    @(negedge clk);
    abort_i = 1;
    @(negedge clk);
    abort_i = 0;
    n_chk++; if (busy_o !== 1'b0 || mem_invalidate_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL idle_abort: busy %b inv %b done %b want 0 0 0", busy_o, mem_invalidate_o, done_o); else n_pass++;
  endtask

  task automatic test_read_3bursts();  run_job(0, 32'h0000_1000, 3, -1, -1, 0); endtask
  task automatic test_write_2bursts(); run_job(1, 32'h0000_2000, 2, -1, -1, 0); endtask
  task automatic test_rd_stall();      run_job(0, 32'h0000_5000, 2, -1, -1, 1); endtask
  task automatic test_zero_bursts();   run_job($urandom % 2 == 1, 32'h0000_6000, 0, -1, -1, 0); endtask
  task automatic test_addr_wrap();
    run_job(0, 32'hFFFF_FFF8, 2, -1, -1, 0);
    run_job(1, 32'hFFFF_FFF8, 2, -1, -1, 0);
  endtask
  task automatic test_abort_rd_wait(); run_job(0, 32'h0000_7000, 2, P_RWAIT, -1, 0); endtask
  task automatic test_reset_mid_write();
    run_job(1, 32'h0000_3000, 2, -1, P_WREQ, 0);
    run_job(1, 32'h0000_4000, 2, -1, -1, 0);
    run_job(0, 32'h0000_4100, 1, -1, -1, 0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 24; j++) begin
      run_job(1'($urandom % 2), $urandom, $urandom_range(0, 4),
              ($urandom % 4 == 0) ? $urandom_range(0, 6) : -1, -1, 1'($urandom % 2));
    end
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_idle_abort();
    test_read_3bursts();
    test_write_2bursts();
    test_rd_stall();
    test_zero_bursts();
    test_addr_wrap();
    test_abort_rd_wait();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
